// File: rtl/proyect_top_pkg.sv
// Shared constants for the PS/2 alarm panel: scan codes, FSM encodings, default thresholds.
// Also holds the digit-key lookup used by the decoder.
package proyect_top_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_GAS   = 8'h34;
  localparam logic [7:0] SC_NOGAS = 8'h31;
  localparam logic [7:0] SC_RESET = 8'h2D;

  localparam int DEF_ALERT_TEMP  = 7;
  localparam int DEF_DANGER_TEMP = 9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_NORMAL  = 2'd1;
  localparam logic [1:0] ST_ALERTA  = 2'd2;
  localparam logic [1:0] ST_PELIGRO = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [3:0] value;
  } digit_t;

  function automatic digit_t scan_to_digit(input logic [7:0] code);
    digit_t d;
    d.hit   = 1'b1;
    d.value = 4'd0;
    case (code)
      8'h45:   d.value = 4'd0;
      8'h16:   d.value = 4'd1;
      8'h1E:   d.value = 4'd2;
      8'h26:   d.value = 4'd3;
      8'h25:   d.value = 4'd4;
      8'h2E:   d.value = 4'd5;
      8'h36:   d.value = 4'd6;
      8'h3D:   d.value = 4'd7;
      8'h3E:   d.value = 4'd8;
      8'h46:   d.value = 4'd9;
      default: d.hit   = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/proyect_top_ps2_rx.sv
// PS/2 receiver: line synchronizers, ps2clk glitch filter, frame capture with
// odd-parity/stop check and a mid-frame inactivity timeout.
module proyect_top_ps2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT     = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  input  logic       rx_en_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLT_RELOAD = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_RELOAD  = TW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_s;
  logic                   dat_s;

  logic [FW-1:0] flt_cnt_q;
  logic          flt_q;
  logic          strobe_q;

  logic          busy_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_byte_q;
  logic          rx_done_q;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Idle PS/2 lines sit high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flt_cnt_q <= FLT_RELOAD;
      flt_q     <= 1'b1;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (clk_s == flt_q) begin
        flt_cnt_q <= FLT_RELOAD;
      end else if (flt_cnt_q == '0) begin
        flt_q     <= clk_s;
        flt_cnt_q <= FLT_RELOAD;
        strobe_q  <= ~clk_s;
      end else begin
        flt_cnt_q <= flt_cnt_q - 1'b1;
      end
    end
  end

  // bit_cnt_q: 1..8 data bits, 9 parity, 10 stop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      to_cnt_q  <= TO_RELOAD;
      rx_byte_q <= 8'd0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      if (!rx_en_i) begin
        busy_q <= 1'b0;
      end else if (strobe_q) begin
        to_cnt_q <= TO_RELOAD;
        if (!busy_q) begin
          if (!dat_s) begin
            busy_q    <= 1'b1;
            bit_cnt_q <= 4'd1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_q <= {dat_s, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            par_q <= dat_s;
          end else begin
            busy_q <= 1'b0;
            if (dat_s && (^{shift_q, par_q})) begin
              rx_byte_q <= shift_q;
              rx_done_q <= 1'b1;
            end
          end
        end
      end else if (busy_q) begin
        if (to_cnt_q == '0) begin
          busy_q <= 1'b0;
        end else begin
          to_cnt_q <= to_cnt_q - 1'b1;
        end
      end
    end
  end

  assign rx_byte_o = rx_byte_q;
  assign rx_done_o = rx_done_q;

endmodule

// File: rtl/proyect_top.sv
// Gas/temperature alarm panel: PS/2 key decoder plus alarm FSM.
// state   | meaning
// IDLE    | no digit since reset/'R'; alarms held off, RESETFSM=1
// NORMAL  | below thresholds, no gas
// ALERTA  | Temps>=ALERT_TEMP or gas present
// PELIGRO | Temps>=DANGER_TEMP with gas present
module proyect_top
  import proyect_top_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT     = 100000,
  parameter int ALERT_TEMP  = DEF_ALERT_TEMP,
  parameter int DANGER_TEMP = DEF_DANGER_TEMP
) (
  input  logic       CLK_G,
  input  logic       reset_G,
  input  logic       ps2data,
  input  logic       ps2clk,
  input  logic       Rx_en,
  output logic [3:0] Temps,
  output logic       RESETFSM,
  output logic       Gas,
  output logic       Alerta,
  output logic       Peligro
);

  logic [7:0] rx_byte;
  logic       rx_done;
  digit_t     key;

  logic [3:0] temps_q;
  logic       gas_q;
  logic       brk_q;
  logic       digit_q;
  logic       soft_q;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       alerta_q;
  logic       peligro_q;
  logic       resetfsm_q;

  proyect_top_ps2_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk_i    (CLK_G),
    .rst_i    (reset_G),
    .ps2clk_i (ps2clk),
    .ps2data_i(ps2data),
    .rx_en_i  (Rx_en),
    .rx_byte_o(rx_byte),
    .rx_done_o(rx_done)
  );

  assign key = scan_to_digit(rx_byte);

  // The byte after a break prefix is the key release: swallow it whatever it is.
  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      temps_q <= 4'd0;
      gas_q   <= 1'b0;
      brk_q   <= 1'b0;
      digit_q <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      digit_q <= 1'b0;
      soft_q  <= 1'b0;
      if (rx_done) begin
        if (brk_q) begin
          brk_q <= 1'b0;
        end else if (rx_byte == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (key.hit) begin
          temps_q <= key.value;
          digit_q <= 1'b1;
        end else if (rx_byte == SC_GAS) begin
          gas_q <= 1'b1;
        end else if (rx_byte == SC_NOGAS) begin
          gas_q <= 1'b0;
        end else if (rx_byte == SC_RESET) begin
          temps_q <= 4'd0;
          gas_q   <= 1'b0;
          soft_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (soft_q) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (digit_q) state_d = ST_NORMAL;
    end else if ((temps_q >= 4'(DANGER_TEMP)) && gas_q) begin
      state_d = ST_PELIGRO;
    end else if ((temps_q >= 4'(ALERT_TEMP)) || gas_q) begin
      state_d = ST_ALERTA;
    end else begin
      state_d = ST_NORMAL;
    end
  end

  // Alarm flags register the decoded next state so they change with state_q.
  always_ff @(posedge CLK_G) begin
    if (reset_G) begin
      state_q    <= ST_IDLE;
      alerta_q   <= 1'b0;
      peligro_q  <= 1'b0;
      resetfsm_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      alerta_q   <= (state_d == ST_ALERTA) || (state_d == ST_PELIGRO);
      peligro_q  <= (state_d == ST_PELIGRO);
      resetfsm_q <= (state_d == ST_IDLE);
    end
  end

  assign Temps    = temps_q;
  assign Gas      = gas_q;
  assign Alerta   = alerta_q;
  assign Peligro  = peligro_q;
  assign RESETFSM = resetfsm_q;

endmodule

// File: tb/tb_proyect_top.sv
// Directed bench for the PS/2 alarm panel: sends whole PS/2 frames and checks panel outputs.
module tb_proyect_top;

  localparam int TO = 2000;

  logic       CLK_G = 1'b0;
  logic       reset_G;
  logic       ps2data;
  logic       ps2clk;
  logic       Rx_en;
  logic [3:0] Temps;
  logic       RESETFSM;
  logic       Gas;
  logic       Alerta;
  logic       Peligro;

  int checks = 0;
  int errors = 0;

  always #5 CLK_G = ~CLK_G;

  proyect_top #(.TIMEOUT(TO)) dut (
    .CLK_G   (CLK_G),
    .reset_G (reset_G),
    .ps2data (ps2data),
    .ps2clk  (ps2clk),
    .Rx_en   (Rx_en),
    .Temps   (Temps),
    .RESETFSM(RESETFSM),
    .Gas     (Gas),
    .Alerta  (Alerta),
    .Peligro (Peligro)
  );

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip_par);
    return {1'b1, (~^d) ^ flip_par, d, 1'b0};
  endfunction

  // b[0] goes on the wire first.
  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2data = b[i];
      repeat (20) @(negedge CLK_G);
      ps2clk = 1'b0;
      repeat (40) @(negedge CLK_G);
      ps2clk = 1'b1;
      repeat (20) @(negedge CLK_G);
    end
    ps2data = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] d);
    send_bits(frame(d, 1'b0), 11);
    repeat (40) @(negedge CLK_G);
  endtask

  task automatic test_reset;
    reset_G = 1'b1; Rx_en = 1'b1; ps2clk = 1'b1; ps2data = 1'b1;
    repeat (5) @(negedge CLK_G);
    reset_G = 1'b0;
    repeat (3) @(negedge CLK_G);
    checks++; if (Temps !== 4'd0) begin errors++; $display("FAIL reset_temps got %0d want 0", Temps); end
    checks++; if (Gas !== 1'b0) begin errors++; $display("FAIL reset_gas got %b want 0", Gas); end
    checks++; if (Alerta !== 1'b0) begin errors++; $display("FAIL reset_alerta got %b want 0", Alerta); end
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL reset_peligro got %b want 0", Peligro); end
    checks++; if (RESETFSM !== 1'b1) begin errors++; $display("FAIL reset_resetfsm got %b want 1", RESETFSM); end
  endtask

  task automatic test_first_digit;
    logic [10:0] v;
    v = 11'b10000101100;  // 0x16: 0,0,1,1,0,1,0,0,0,0,1 on the wire
    send_bits(v, 11);
    repeat (40) @(negedge CLK_G);
    checks++; if (Temps !== 4'd1) begin errors++; $display("FAIL digit1_temps got %0d want 1", Temps); end
    checks++; if (RESETFSM !== 1'b0) begin errors++; $display("FAIL digit1_resetfsm got %b want 0", RESETFSM); end
    checks++; if (Alerta !== 1'b0) begin errors++; $display("FAIL digit1_alerta got %b want 0", Alerta); end
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL digit1_peligro got %b want 0", Peligro); end
  endtask

  task automatic test_danger_and_soft_reset;
    send_key(8'h46);
    send_key(8'h34);
    checks++; if (Temps !== 4'd9) begin errors++; $display("FAIL danger_temps got %0d want 9", Temps); end
    checks++; if (Gas !== 1'b1) begin errors++; $display("FAIL danger_gas got %b want 1", Gas); end
    checks++; if (Alerta !== 1'b1) begin errors++; $display("FAIL danger_alerta got %b want 1", Alerta); end
    checks++; if (Peligro !== 1'b1) begin errors++; $display("FAIL danger_peligro got %b want 1", Peligro); end
    send_key(8'h2D);
    checks++; if (Temps !== 4'd0) begin errors++; $display("FAIL soft_temps got %0d want 0", Temps); end
    checks++; if (Gas !== 1'b0) begin errors++; $display("FAIL soft_gas got %b want 0", Gas); end
    checks++; if (Alerta !== 1'b0) begin errors++; $display("FAIL soft_alerta got %b want 0", Alerta); end
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL soft_peligro got %b want 0", Peligro); end
    checks++; if (RESETFSM !== 1'b1) begin errors++; $display("FAIL soft_resetfsm got %b want 1", RESETFSM); end
  endtask

  task automatic test_bad_parity;
    send_bits(frame(8'h3D, 1'b1), 11);
    repeat (40) @(negedge CLK_G);
    checks++; if (Temps !== 4'd0) begin errors++; $display("FAIL parity_temps got %0d want 0", Temps); end
    checks++; if (RESETFSM !== 1'b1) begin errors++; $display("FAIL parity_resetfsm got %b want 1", RESETFSM); end
  endtask

  task automatic test_break;
    send_key(8'hF0);
    send_key(8'h16);
    checks++; if (Temps !== 4'd0) begin errors++; $display("FAIL break_temps got %0d want 0", Temps); end
    checks++; if (RESETFSM !== 1'b1) begin errors++; $display("FAIL break_resetfsm got %b want 1", RESETFSM); end
    send_key(8'h36);
    checks++; if (Temps !== 4'd6) begin errors++; $display("FAIL make6_temps got %0d want 6", Temps); end
    checks++; if (Alerta !== 1'b0) begin errors++; $display("FAIL make6_alerta got %b want 0", Alerta); end
    checks++; if (RESETFSM !== 1'b0) begin errors++; $display("FAIL make6_resetfsm got %b want 0", RESETFSM); end
  endtask

  task automatic test_rx_disable;
    Rx_en = 1'b0;
    send_key(8'h46);
    Rx_en = 1'b1;
    repeat (5) @(negedge CLK_G);
    checks++; if (Temps !== 4'd6) begin errors++; $display("FAIL rxen_temps got %0d want 6", Temps); end
  endtask

  task automatic test_timeout;
    send_bits(frame(8'h3E, 1'b0), 5);
    repeat (TO + 200) @(negedge CLK_G);
    send_key(8'h3E);
    checks++; if (Temps !== 4'd8) begin errors++; $display("FAIL timeout_temps got %0d want 8", Temps); end
    checks++; if (Alerta !== 1'b1) begin errors++; $display("FAIL timeout_alerta got %b want 1", Alerta); end
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL timeout_peligro got %b want 0", Peligro); end
  endtask

  task automatic test_thresholds;
    send_key(8'h3D);
    checks++; if (Alerta !== 1'b1) begin errors++; $display("FAIL t7_alerta got %b want 1", Alerta); end
    send_key(8'h36);
    checks++; if (Alerta !== 1'b0) begin errors++; $display("FAIL t6_alerta got %b want 0", Alerta); end
    send_key(8'h34);
    checks++; if (Alerta !== 1'b1) begin errors++; $display("FAIL t6gas_alerta got %b want 1", Alerta); end
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL t6gas_peligro got %b want 0", Peligro); end
    send_key(8'h3E);
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL t8gas_peligro got %b want 0", Peligro); end
    send_key(8'h46);
    checks++; if (Peligro !== 1'b1) begin errors++; $display("FAIL t9gas_peligro got %b want 1", Peligro); end
    send_key(8'h31);
    checks++; if (Gas !== 1'b0) begin errors++; $display("FAIL nogas_gas got %b want 0", Gas); end
    checks++; if (Peligro !== 1'b0) begin errors++; $display("FAIL nogas_peligro got %b want 0", Peligro); end
    checks++; if (Alerta !== 1'b1) begin errors++; $display("FAIL nogas_alerta got %b want 1", Alerta); end
  endtask

  task automatic test_back_to_back;
    send_key(8'hE0);
    send_key(8'h45);
    checks++; if (Temps !== 4'd0) begin errors++; $display("FAIL ext0_temps got %0d want 0", Temps); end
    checks++; if (Alerta !== 1'b0) begin errors++; $display("FAIL ext0_alerta got %b want 0", Alerta); end
    checks++; if (RESETFSM !== 1'b0) begin errors++; $display("FAIL ext0_resetfsm got %b want 0", RESETFSM); end
  endtask

  initial begin
    test_reset;
    test_first_digit;
    test_danger_and_soft_reset;
    test_bad_parity;
    test_break;
    test_rx_disable;
    test_timeout;
    test_thresholds;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
